rs_syndrome: RTL and testbench

Streaming Reed-Solomon syndrome calculator for RS(N_LEN, K_LEN) over GF(2^SYMB_WIDTH). It sits directly downstream of the codeword input bus and upstream of the key-equation solver. It accepts BUS_WIDTH_IN_SYMB symbols per beat and evaluates the received polynomial at the ROOTS_NUM consecutive roots alpha^(FIRST_ROOT+j) by Horner's rule. It emits all syndromes plus an error-detected flag once per codeword.

---
 rtl/rs_syndrome_pkg.sv | 46 ++++
 rtl/rs_syndrome_gf_const_mult.sv | 21 ++
 rtl/rs_syndrome.sv | 139 +++++++++++++
 tb/tb_rs_syndrome.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_syndrome_pkg.sv
// GF(2^8) constants, syndrome types and elaboration-time alpha-power helpers
// for the streaming RS(255,239) syndrome calculator.
package rs_syndrome_pkg;

  localparam int N_LEN             = 255;
  localparam int K_LEN             = 239;
  localparam int ROOTS_NUM         = N_LEN - K_LEN;
  localparam int SYMB_WIDTH        = 8;
  localparam int BUS_WIDTH_IN_SYMB = 4;
  localparam int FIRST_ROOT        = 1;
  localparam int POLY              = 285;
  localparam int SYMB_NUM          = 1 << SYMB_WIDTH;

  localparam int NBEATS     = (N_LEN + BUS_WIDTH_IN_SYMB - 1) / BUS_WIDTH_IN_SYMB;
  localparam int LAST_LANES = N_LEN - (NBEATS - 1) * BUS_WIDTH_IN_SYMB;
  localparam int CNT_W      = $clog2(NBEATS);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [ROOTS_NUM-1:0] synd_t;

  // alpha^e by repeated multiply-by-x with reduction by the field polynomial
  function automatic symb_t gen_alpha_to_symb(input int e);
    logic [SYMB_WIDTH:0] v;
    logic [SYMB_WIDTH:0] poly_v;
    poly_v = POLY[SYMB_WIDTH:0];
    v = 1;
    for (int n = 0; n < e; n++) begin
      v = v << 1;
      if (v[SYMB_WIDTH]) v = v ^ poly_v;
    end
    return v[SYMB_WIDTH-1:0];
  endfunction

  function automatic symb_t alpha_pow(input int e);
    return gen_alpha_to_symb(e % (SYMB_NUM - 1));
  endfunction

  // Column c holds alpha^(exp+c): the image of basis element alpha^c.
  function automatic logic [SYMB_WIDTH*SYMB_WIDTH-1:0] const_mult_matrix(input int exp);
    logic [SYMB_WIDTH*SYMB_WIDTH-1:0] m;
    m = '0;
    for (int c = 0; c < SYMB_WIDTH; c++) m[c*SYMB_WIDTH +: SYMB_WIDTH] = alpha_pow(exp + c);
    return m;
  endfunction

endpackage

// File: rtl/rs_syndrome_gf_const_mult.sv
// Combinational multiply of one GF symbol by the constant alpha^EXP,
// realised as a fixed XOR matrix resolved at elaboration.
module gf_const_mult
  import rs_syndrome_pkg::*;
#(
  parameter int EXP = 0
) (
  input  symb_t din,
  output symb_t dout
);

  localparam logic [SYMB_WIDTH*SYMB_WIDTH-1:0] MAT = const_mult_matrix(EXP);

  always_comb begin
    dout = '0;
    for (int c = 0; c < SYMB_WIDTH; c++) begin
      if (din[c]) dout = dout ^ MAT[c*SYMB_WIDTH +: SYMB_WIDTH];
    end
  end

endmodule

// File: rtl/rs_syndrome.sv
// Streaming RS syndrome calculator: Horner evaluation at ROOTS_NUM roots, W symbols/beat.
// RS_SYND_PIPE_EN adds an input register stage (latency 2 instead of 1); no backpressure.
module rs_syndrome
  import rs_syndrome_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  input  logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0] s_data,
  input  logic                                  s_last,
  output logic                                  s_ready,
  output logic                                  synd_valid,
  output logic [ROOTS_NUM*SYMB_WIDTH-1:0]       synd,
  output logic                                  err_det,
  output logic                                  len_err
);

  localparam int W = BUS_WIDTH_IN_SYMB;
  localparam int R = LAST_LANES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  symb_t            lane       [W];
  symb_t            prod_full  [ROOTS_NUM][W];
  symb_t            prod_short [ROOTS_NUM][R];
  synd_t            t_full, t_short, t_sel;
  synd_t            fb_full, fb_short;
  synd_t            acc_q, acc_next;
  logic [CNT_W-1:0] beat_cnt;
  logic             cnt_last, beat_first, beat_final, beat_len_err;

  logic             a_vld, a_first, a_final, a_short, a_len_err;
  synd_t            a_t;

  assign s_ready = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign lane[i] = s_data[i*SYMB_WIDTH +: SYMB_WIDTH];
  end

  // Per root: lane weights for full and short beats, plus the Horner shift by alpha^(k*M).
  for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_root
    localparam int K = FIRST_ROOT + j;
    for (genvar i = 0; i < W; i++) begin : g_full
      gf_const_mult #(.EXP(K * (W - 1 - i))) u_mul (.din(lane[i]), .dout(prod_full[j][i]));
    end
    for (genvar i = 0; i < R; i++) begin : g_short
      gf_const_mult #(.EXP(K * (R - 1 - i))) u_mul (.din(lane[i]), .dout(prod_short[j][i]));
    end
    gf_const_mult #(.EXP(K * W)) u_fb_full  (.din(acc_q[j]), .dout(fb_full[j]));
    gf_const_mult #(.EXP(K * R)) u_fb_short (.din(acc_q[j]), .dout(fb_short[j]));
  end

  always_comb begin
    t_full  = '0;
    t_short = '0;
    for (int j = 0; j < ROOTS_NUM; j++) begin
      for (int i = 0; i < W; i++) t_full[j] = t_full[j] ^ prod_full[j][i];
      for (int i = 0; i < R; i++) t_short[j] = t_short[j] ^ prod_short[j][i];
    end
  end

  // A premature s_last still uses the full-beat weights; only the counted last beat is short.
  assign cnt_last     = (beat_cnt == LAST_CNT);
  assign beat_first   = (beat_cnt == '0);
  assign beat_final   = s_last | cnt_last;
  assign beat_len_err = s_last ^ cnt_last;
  assign t_sel        = cnt_last ? t_short : t_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (s_valid) begin
      beat_cnt <= beat_final ? '0 : beat_cnt + 1'b1;
    end
  end

`ifdef RS_SYND_PIPE_EN
  logic  p_vld, p_first, p_final, p_short, p_len_err;
  synd_t p_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld     <= 1'b0;
      p_first   <= 1'b0;
      p_final   <= 1'b0;
      p_short   <= 1'b0;
      p_len_err <= 1'b0;
      p_t       <= '0;
    end else begin
      p_vld     <= s_valid;
      p_first   <= beat_first;
      p_final   <= beat_final;
      p_short   <= cnt_last;
      p_len_err <= beat_len_err;
      p_t       <= t_sel;
    end
  end

  assign a_vld     = p_vld;
  assign a_first   = p_first;
  assign a_final   = p_final;
  assign a_short   = p_short;
  assign a_len_err = p_len_err;
  assign a_t       = p_t;
`else
  assign a_vld     = s_valid;
  assign a_first   = beat_first;
  assign a_final   = beat_final;
  assign a_short   = cnt_last;
  assign a_len_err = beat_len_err;
  assign a_t       = t_sel;
`endif

  always_comb begin
    acc_next = '0;
    for (int j = 0; j < ROOTS_NUM; j++) begin
      acc_next[j] = a_first ? a_t[j] : ((a_short ? fb_short[j] : fb_full[j]) ^ a_t[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      synd_valid <= 1'b0;
      synd       <= '0;
      err_det    <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      synd_valid <= a_vld & a_final;
      if (a_vld) acc_q <= acc_next;
      if (a_vld && a_final) begin
        synd    <= acc_next;
        err_det <= |acc_next;
        len_err <= a_len_err;
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome.sv
// Scoreboard bench for rs_syndrome: an independent GF(2^8) model predicts each
// syndrome pulse (values, flags and arrival cycle) as the final beat is driven.
module tb_rs_syndrome;

  localparam int W  = 4;
  localparam int NB = 64;
  localparam int RN = 16;
  localparam int NL = 255;
`ifdef RS_SYND_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst, s_valid, s_last, s_ready, synd_valid, err_det, len_err;
  logic [W*8-1:0] s_data;
  logic [RN*8-1:0] synd;

  rs_syndrome dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .synd_valid(synd_valid), .synd(synd),
    .err_det(err_det), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Independent GF(2^8) arithmetic, x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] alog [255];
  logic [7:0] cw [$];

  // Direct evaluation: symbol n of count has degree count-1-n
  function automatic logic [127:0] model(input int count);
    logic [127:0] s;
    s = '0;
    for (int j = 0; j < RN; j++) begin
      for (int n = 0; n < count; n++) begin
        if (cw[n] != 8'h00)
          s[j*8 +: 8] = s[j*8 +: 8] ^ gf_mul(cw[n], alog[((j + 1) * (count - 1 - n)) % 255]);
      end
    end
    return s;
  endfunction

  // Codeword = random message polynomial times the generator polynomial
  task automatic make_codeword();
    logic [7:0] g [17];
    logic [7:0] c [NL];
    logic [7:0] m;
    g[0] = 8'h01;
    for (int d = 1; d < 17; d++) g[d] = 8'h00;
    for (int j = 0; j < RN; j++) begin
      for (int d = j + 1; d >= 1; d--) g[d] = g[d-1] ^ gf_mul(g[d], alog[j+1]);
      g[0] = gf_mul(g[0], alog[j+1]);
    end
    for (int n = 0; n < NL; n++) c[n] = 8'h00;
    for (int a = 0; a < 239; a++) begin
      m = 8'($urandom);
      for (int b = 0; b < 17; b++) c[a+b] = c[a+b] ^ gf_mul(m, g[b]);
    end
    cw.delete();
    for (int n = 0; n < NL; n++) cw.push_back(c[NL-1-n]);
  endtask

  task automatic fill_cw(input int count, input logic [7:0] val);
    cw.delete();
    for (int n = 0; n < count; n++) cw.push_back(val);
  endtask

  typedef struct {
    logic [127:0] synd;
    logic         err;
    logic         len;
    int           cyc;
  } exp_t;
  exp_t sb [$];

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = $urandom;
    end
  endtask

  // Drives nbeats beats from cw; lanes past the end of cw carry junk.
  task automatic send(input int nbeats, input bit with_last, input int gap_max,
                      input bit push, input logic [127:0] esynd, input bit elen);
    int idx;
    for (int b = 0; b < nbeats; b++) begin
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
      @(negedge clk);
      s_valid = 1'b1;
      s_last  = with_last && (b == nbeats - 1);
      for (int i = 0; i < W; i++) begin
        idx = b * W + i;
        s_data[i*8 +: 8] = (idx < cw.size()) ? cw[idx] : 8'($urandom);
      end
      if (push && b == nbeats - 1) sb.push_back('{esynd, |esynd, elen, cyc + LAT});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (synd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got synd_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check_eq("synd", synd, e.synd);
        check_eq("err_det", 128'(err_det), 128'(e.err));
        check_eq("len_err", 128'(len_err), 128'(e.len));
        check_eq("latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    logic [7:0] x;
    logic [127:0] e;
    x = 8'h01;
    for (int k = 0; k < 255; k++) begin
      alog[k] = x;
      x = gf_mul(x, 8'h02);
    end

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_synd_valid", 128'(synd_valid), 128'(0));
    check_eq("rst_synd", synd, 128'(0));
    check_eq("rst_err_det", 128'(err_det), 128'(0));
    check_eq("rst_len_err", 128'(len_err), 128'(0));
    check_eq("rst_s_ready", 128'(s_ready), 128'(1));
    rst = 1'b0;
    idle(2);

    // All-zero codeword
    fill_cw(NL, 8'h00);
    send(NB, 1, 0, 1, '0, 0);
    idle(3);

    // 0x01 in the final (degree-0) symbol
    fill_cw(NL, 8'h00);
    cw[NL-1] = 8'h01;
    send(NB, 1, 0, 1, {RN{8'h01}}, 0);
    idle(3);

    // 0x01 in the first (degree-254) symbol: S_j = alpha^(254*(j+1))
    fill_cw(NL, 8'h00);
    cw[0] = 8'h01;
    for (int j = 0; j < RN; j++) e[j*8 +: 8] = alog[(254 * (j + 1)) % 255];
    send(NB, 1, 0, 1, e, 0);
    idle(3);

    // Valid codewords with random gaps, then one corrupted symbol
    make_codeword();
    send(NB, 1, 2, 1, '0, 0);
    make_codeword();
    send(NB, 1, 2, 1, '0, 0);
    make_codeword();
    cw[100] = (cw[100] == 8'h5A) ? 8'hA5 : 8'h5A;
    send(NB, 1, 2, 1, model(NL), 0);

    // Full-rate back-to-back
    make_codeword();
    send(NB, 1, 0, 1, '0, 0);
    make_codeword();
    cw[0] = cw[0] ^ 8'h01;
    send(NB, 1, 0, 1, model(NL), 0);
    idle(3);

    // Early s_last on beat 10, then a clean codeword
    cw.delete();
    for (int n = 0; n < 11 * W; n++) cw.push_back(8'($urandom));
    send(11, 1, 0, 1, model(11 * W), 1);
    make_codeword();
    send(NB, 1, 0, 1, '0, 0);
    idle(2);

    // Missing s_last on beat 63, next codeword starts immediately
    cw.delete();
    for (int n = 0; n < NL; n++) cw.push_back(8'($urandom));
    send(NB, 0, 0, 1, model(NL), 1);
    make_codeword();
    send(NB, 1, 0, 1, '0, 0);
    idle(2);

    // Reset at beat 30 discards the partial codeword
    make_codeword();
    send(30, 0, 0, 0, '0, 0);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    make_codeword();
    cw[7] = cw[7] ^ 8'h33;
    send(NB, 1, 1, 1, model(NL), 0);
    idle(3);

    // Reset right after a final beat drops any result still in the pipeline
    make_codeword();
    cw[200] = cw[200] ^ 8'h81;
    send(NB, 1, 0, (LAT == 1), model(NL), 0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    make_codeword();
    send(NB, 1, 0, 1, '0, 0);
    idle(10);

    check_eq("sb_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
